// File: rtl/vga_pkg.sv
// Shared raster definitions: default 640x480@60 timing and the coordinate type used by
// the timing generator and every overlay that decodes x,y.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int CLK_DIV_DEF   = 2;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int BLINK_BIT_DEF = 5;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator (master) to overlays and the colour mux (slave).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       pix_en;
    logic       vga_clk;
    coord_t     x;
    coord_t     y;
    logic       hsync_n;
    logic       vsync_n;
    logic       video_on;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic       blink;

    modport master (
        output pix_en, vga_clk, x, y, hsync_n, vsync_n, video_on, frame_start, frame_cnt, blink
    );

    modport slave (
        input pix_en, vga_clk, x, y, hsync_n, vsync_n, video_on, frame_start, frame_cnt, blink
    );

endinterface

// File: rtl/pix_clk_div.sv
// Pixel-rate divider: one-clk pix_en strobe every CLK_DIV clocks and a registered
// 50% duty pixel clock for the DAC.
module pix_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             vga_clk_q, vga_clk_d;

    assign pix_en_o  = (div_cnt_q == DIV_LAST);
    assign vga_clk_o = vga_clk_q;

    // NOTE: every always_comb output gets a default on its first line so no path can infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (pix_en_o) begin
            div_cnt_d = '0;
        end
        vga_clk_d = (div_cnt_d >= DIV_HALF);
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            vga_clk_q <= vga_clk_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: x,y counters plus registered hsync/vsync/video_on/frame_start.
// Define VGA_FRAME_CNT_EN to build the frame counter and blink output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int BLINK_BIT = BLINK_BIT_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   pix_en;
    logic   vga_clk;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_n_q, vsync_n_q, video_on_q, frame_start_q;
    logic   frame_hit;

    pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en_o  (pix_en),
        .vga_clk_o (vga_clk)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    assign frame_hit = pix_en && (x_d == '0) && (y_d == '0);

    // Strobes are decoded from next-state counters so they line up with the x,y they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_n_q     <= !((x_d >= HS_START) && (x_d < HS_END));
            vsync_n_q     <= !((y_d >= VS_START) && (y_d < VS_END));
            video_on_q    <= (x_d < H_VIS) && (y_d < V_VIS);
            frame_start_q <= frame_hit;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_hit) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
    assign vga.blink     = frame_cnt_q[BLINK_BIT];
`else
    // Without the counter the text overlays stay permanently visible.
    assign vga.frame_cnt = '0;
    assign vga.blink     = 1'b1;
`endif

    assign vga.pix_en      = pix_en;
    assign vga.vga_clk     = vga_clk;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync_n     = hsync_n_q;
    assign vga.vsync_n     = vsync_n_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 640x480 timing for reset and line checks,
// a miniature raster (15x8 pixels) for frame-level, vertical and frame-counter checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    // Miniature raster: hsync x=10..12, vsync y=5..6, frame = 15*8*2 = 240 clks.
    localparam int S_H_ACTIVE = 8;
    localparam int S_H_FP     = 2;
    localparam int S_H_SYNC   = 3;
    localparam int S_H_BP     = 2;
    localparam int S_V_ACTIVE = 4;
    localparam int S_V_FP     = 1;
    localparam int S_V_SYNC   = 2;
    localparam int S_V_BP     = 1;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rst_s_n;
    int   checks;
    int   errors;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif_s ();

    vga_timing_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif.master)
    );

    vga_timing_gen #(
        .CLK_DIV  (2),
        .H_ACTIVE (S_H_ACTIVE),
        .H_FP     (S_H_FP),
        .H_SYNC   (S_H_SYNC),
        .H_BP     (S_H_BP),
        .V_ACTIVE (S_V_ACTIVE),
        .V_FP     (S_V_FP),
        .V_SYNC   (S_V_SYNC),
        .V_BP     (S_V_BP)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_s_n),
        .vga   (vif_s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input bit sel, input int tx, input int ty, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            if (sel ? (int'(vif_s.x) == tx && int'(vif_s.y) == ty)
                    : (int'(vif.x) == tx && int'(vif.y) == ty)) break;
            tick();
            n++;
        end
        if (n >= budget) begin
            errors++;
            checks++;
            $display("FAIL step_to timeout: never reached x=%0d y=%0d", tx, ty);
        end
    endtask

    task automatic apply_vec(input bit sel, input vec_t v, input int budget);
        step_to(sel, v.x, v.y, budget);
        if (sel) begin
            check($sformatf("s hsync_n @%0d,%0d", v.x, v.y), 32'(vif_s.hsync_n), 32'(v.hs));
            check($sformatf("s vsync_n @%0d,%0d", v.x, v.y), 32'(vif_s.vsync_n), 32'(v.vs));
            check($sformatf("s video_on @%0d,%0d", v.x, v.y), 32'(vif_s.video_on), 32'(v.vo));
        end else begin
            check($sformatf("hsync_n @%0d,%0d", v.x, v.y), 32'(vif.hsync_n), 32'(v.hs));
            check($sformatf("vsync_n @%0d,%0d", v.x, v.y), 32'(vif.vsync_n), 32'(v.vs));
            check($sformatf("video_on @%0d,%0d", v.x, v.y), 32'(vif.video_on), 32'(v.vo));
        end
    endtask

    // Wait for the next frame_start on the miniature raster; returns clks waited.
    task automatic wait_fs_s(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!vif_s.frame_start && waited < budget);
        if (!vif_s.frame_start) begin
            errors++;
            checks++;
            $display("FAIL frame_start timeout after %0d clks", waited);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int frames);
`ifdef VGA_FRAME_CNT_EN
        return 8'(frames);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic exp_blink(input int frames);
        logic [7:0] c;
`ifdef VGA_FRAME_CNT_EN
        c = 8'(frames);
        return c[5];
`else
        c = 8'(frames);
        return c[0] | 1'b1;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t line_vec[8];
        vec_t vert_vec[9];
        int   cnt_a;
        int   cnt_b;
        int   waited;
        int   frames;

        line_vec = '{
            '{0,   0, 1'b1, 1'b1, 1'b1},
            '{639, 0, 1'b1, 1'b1, 1'b1},
            '{640, 0, 1'b1, 1'b1, 1'b0},
            '{655, 0, 1'b1, 1'b1, 1'b0},
            '{656, 0, 1'b0, 1'b1, 1'b0},
            '{751, 0, 1'b0, 1'b1, 1'b0},
            '{752, 0, 1'b1, 1'b1, 1'b0},
            '{799, 0, 1'b1, 1'b1, 1'b0}
        };
        vert_vec = '{
            '{0,  0, 1'b1, 1'b1, 1'b1},
            '{7,  3, 1'b1, 1'b1, 1'b1},
            '{8,  3, 1'b1, 1'b1, 1'b0},
            '{0,  4, 1'b1, 1'b1, 1'b0},
            '{0,  5, 1'b1, 1'b0, 1'b0},
            '{10, 5, 1'b0, 1'b0, 1'b0},
            '{14, 6, 1'b1, 1'b0, 1'b0},
            '{0,  7, 1'b1, 1'b1, 1'b0},
            '{14, 7, 1'b1, 1'b1, 1'b0}
        };

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        rst_s_n = 1'b0;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst x", 32'(vif.x), 32'(H_TOTAL - 1));
        check("rst y", 32'(vif.y), 32'(V_TOTAL - 1));
        check("rst hsync_n", 32'(vif.hsync_n), 32'd1);
        check("rst vsync_n", 32'(vif.vsync_n), 32'd1);
        check("rst video_on", 32'(vif.video_on), 32'd0);
        check("rst vga_clk", 32'(vif.vga_clk), 32'd0);
        check("rst frame_start", 32'(vif.frame_start), 32'd0);
        check("rst frame_cnt", 32'(vif.frame_cnt), 32'd0);

        // Release: pix_en low before edge 1, high before edge 2, (0,0) after edge 2
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        #1;
        check("rel pix_en pre-edge1", 32'(vif.pix_en), 32'd0);
        tick();
        check("rel pix_en pre-edge2", 32'(vif.pix_en), 32'd1);
        check("rel vga_clk high", 32'(vif.vga_clk), 32'd1);
        check("rel x holds", 32'(vif.x), 32'(H_TOTAL - 1));
        tick();
        check("rel x", 32'(vif.x), 32'd0);
        check("rel y", 32'(vif.y), 32'd0);
        check("rel video_on", 32'(vif.video_on), 32'd1);
        check("rel frame_start", 32'(vif.frame_start), 32'd1);
        check("rel pix_en low", 32'(vif.pix_en), 32'd0);
        tick();
        check("rel frame_start one clk", 32'(vif.frame_start), 32'd0);
        check("rel x holds between strobes", 32'(vif.x), 32'd0);

        // Line scan on full timing
        for (int i = 0; i < 8; i++) begin
            apply_vec(1'b0, line_vec[i], 4000);
        end
        tick();
        tick();
        check("wrap x", 32'(vif.x), 32'd0);
        check("wrap y", 32'(vif.y), 32'd1);
        check("wrap video_on", 32'(vif.video_on), 32'd1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 2 * H_TOTAL; i++) begin
            if (!vif.hsync_n) cnt_a++;
            if (vif.video_on) cnt_b++;
            tick();
        end
        check("hsync low clks per line", 32'(cnt_a), 32'd192);
        check("video_on clks per line", 32'(cnt_b), 32'd1280);
        check("next line", 32'(vif.y), 32'd2);

        // Vertical behaviour on the miniature raster
        for (int i = 0; i < 9; i++) begin
            apply_vec(1'b1, vert_vec[i], 400);
        end
        tick();
        tick();
        check("s frame wrap x", 32'(vif_s.x), 32'd0);
        check("s frame wrap y", 32'(vif_s.y), 32'd0);
        check("s frame wrap frame_start", 32'(vif_s.frame_start), 32'd1);
        wait_fs_s(400, waited);
        check("s frame period clks", 32'(waited), 32'd240);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 240; i++) begin
            if (!vif_s.vsync_n) cnt_a++;
            if (vif_s.video_on && int'(vif_s.y) >= S_V_ACTIVE) cnt_b++;
            tick();
        end
        check("s vsync low clks per frame", 32'(cnt_a), 32'd60);
        check("s video_on below active", 32'(cnt_b), 32'd0);

        // Asynchronous reset mid-frame, inside both sync pulses
        step_to(1'b1, 11, 5, 400);
        check("mid pre hsync_n", 32'(vif_s.hsync_n), 32'd0);
        check("mid pre vsync_n", 32'(vif_s.vsync_n), 32'd0);
        #2;
        rst_s_n = 1'b0;
        #1;
        check("mid rst x", 32'(vif_s.x), 32'd14);
        check("mid rst y", 32'(vif_s.y), 32'd7);
        check("mid rst hsync_n", 32'(vif_s.hsync_n), 32'd1);
        check("mid rst vsync_n", 32'(vif_s.vsync_n), 32'd1);
        check("mid rst video_on", 32'(vif_s.video_on), 32'd0);
        check("mid rst pix_en", 32'(vif_s.pix_en), 32'd0);
        check("mid rst frame_cnt", 32'(vif_s.frame_cnt), 32'd0);
        @(negedge clk);
        rst_s_n = 1'b1;
        tick();
        check("mid restart holds", 32'(vif_s.x), 32'd14);
        tick();
        check("mid restart x", 32'(vif_s.x), 32'd0);
        check("mid restart y", 32'(vif_s.y), 32'd0);
        check("mid restart frame_start", 32'(vif_s.frame_start), 32'd1);

        // Frame counter and blink
        frames = 1;
        check("frame_cnt 1", 32'(vif_s.frame_cnt), 32'(exp_cnt(frames)));
        repeat (2) begin
            wait_fs_s(400, waited);
            frames++;
        end
        check("frame_cnt 3", 32'(vif_s.frame_cnt), 32'(exp_cnt(frames)));
        check("blink @3", 32'(vif_s.blink), 32'(exp_blink(frames)));
        while (frames < 64) begin
            wait_fs_s(400, waited);
            frames++;
            if (frames == 31 || frames == 32 || frames == 63 || frames == 64) begin
                check($sformatf("blink @%0d", frames), 32'(vif_s.blink), 32'(exp_blink(frames)));
                check($sformatf("frame_cnt @%0d", frames), 32'(vif_s.frame_cnt),
                      32'(exp_cnt(frames)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
